// File: rtl/gpu2d_bg_tile_row_fetcher.sv
// Background tile row fetcher: one RAM read per (tile,row,flip) request,
// then streams the 16 colour indices of that row over valid/ready.
module gpu2d_bg_tile_row_fetcher #(
  parameter int unsigned ADDR_WIDTH    = 12,
  parameter int unsigned PIX_PER_ROW   = 16,
  parameter int unsigned COL_IDX_WIDTH = 6
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   io_req_valid,
  output logic                                   io_req_ready,
  input  logic [ADDR_WIDTH-5:0]                  io_req_tileIdx,
  input  logic [3:0]                             io_req_rowIdx,
  input  logic                                   io_req_hFlip,
  input  logic                                   io_req_vFlip,
  output logic                                   io_rdEn,
  output logic [ADDR_WIDTH-1:0]                  io_rdAddr,
  input  logic [PIX_PER_ROW*COL_IDX_WIDTH-1:0]   io_rdData,
  output logic                                   io_pop_valid,
  input  logic                                   io_pop_ready,
  output logic [COL_IDX_WIDTH-1:0]               io_pop_colIdx,
  output logic [3:0]                             io_pop_pxIdx,
  output logic                                   io_pop_isTransparent,
  output logic                                   io_pop_last
);

  localparam int unsigned PX_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    STREAM  = 2'd2
  } state_t;

  state_t                                      state_q;
  state_t                                      state_d;
  logic                                        hflip_q;
  logic [PX_W-1:0]                             cnt_q;
  logic [PIX_PER_ROW-1:0][COL_IDX_WIDTH-1:0]   row_q;
  logic [PX_W-1:0]                             px_sel;
  logic                                        pop_fire;
  logic                                        last_beat;
  logic                                        req_fire;

  // Next-state logic plus the combinational request/read handshake
  always_comb begin
    state_d      = state_q;
    io_req_ready = 1'b0;
    io_rdEn      = 1'b0;
    io_rdAddr    = '0;
    pop_fire     = io_pop_valid & io_pop_ready;
    last_beat    = (state_q == STREAM) & pop_fire & (cnt_q == 4'hF);
    io_req_ready = (state_q == IDLE) | last_beat;
    req_fire     = io_req_valid & io_req_ready;

    if (req_fire) begin
      io_rdEn   = 1'b1;
      io_rdAddr = {io_req_tileIdx, io_req_vFlip ? ~io_req_rowIdx : io_req_rowIdx};
    end

    case (state_q)
      IDLE:    if (req_fire) state_d = CAPTURE;
      CAPTURE: state_d = STREAM;
      STREAM:  if (last_beat) state_d = req_fire ? CAPTURE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Row register is loaded once per request so later RAM reads cannot disturb it
  always_ff @(posedge clk) begin
    if (reset) begin
      hflip_q <= 1'b0;
      cnt_q   <= '0;
      row_q   <= '0;
    end else begin
      if (req_fire) hflip_q <= io_req_hFlip;
      if (state_q == CAPTURE) begin
        row_q <= io_rdData;
        cnt_q <= '0;
      end else if (pop_fire) begin
        cnt_q <= cnt_q + 4'd1;
      end
    end
  end

  always_comb begin
    px_sel               = hflip_q ? ~cnt_q : cnt_q;
    io_pop_valid         = (state_q == STREAM);
    io_pop_pxIdx         = cnt_q;
    io_pop_colIdx        = row_q[px_sel];
    io_pop_isTransparent = (io_pop_colIdx == '0);
    io_pop_last          = (cnt_q == 4'hF);
  end

endmodule

// File: tb/tb_gpu2d_bg_tile_row_fetcher.sv
// Directed self-checking bench for the BG tile row fetcher with a
// behavioural 4096x96 RAM that returns data the cycle after rdEn.
module tb_gpu2d_bg_tile_row_fetcher;

  typedef logic [5:0] row_t [16];

  logic        clk = 1'b0;
  logic        reset;
  logic        io_req_valid;
  logic        io_req_ready;
  logic [7:0]  io_req_tileIdx;
  logic [3:0]  io_req_rowIdx;
  logic        io_req_hFlip;
  logic        io_req_vFlip;
  logic        io_rdEn;
  logic [11:0] io_rdAddr;
  logic [95:0] io_rdData;
  logic        io_pop_valid;
  logic        io_pop_ready;
  logic [5:0]  io_pop_colIdx;
  logic [3:0]  io_pop_pxIdx;
  logic        io_pop_isTransparent;
  logic        io_pop_last;

  logic [95:0] mem [0:4095];
  int n_cmp = 0;
  int n_bad = 0;

  row_t pat_a, pat_b, pat_c, pat_d;

  gpu2d_bg_tile_row_fetcher dut (
    .clk(clk), .reset(reset),
    .io_req_valid(io_req_valid), .io_req_ready(io_req_ready),
    .io_req_tileIdx(io_req_tileIdx), .io_req_rowIdx(io_req_rowIdx),
    .io_req_hFlip(io_req_hFlip), .io_req_vFlip(io_req_vFlip),
    .io_rdEn(io_rdEn), .io_rdAddr(io_rdAddr), .io_rdData(io_rdData),
    .io_pop_valid(io_pop_valid), .io_pop_ready(io_pop_ready),
    .io_pop_colIdx(io_pop_colIdx), .io_pop_pxIdx(io_pop_pxIdx),
    .io_pop_isTransparent(io_pop_isTransparent), .io_pop_last(io_pop_last)
  );

  always #5 clk = ~clk;

  // RAM model; output is garbage whenever no read was issued
  always @(posedge clk) begin
    if (io_rdEn) io_rdData <= mem[io_rdAddr];
    else         io_rdData <= {$urandom, $urandom, $urandom};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [95:0] pack_row(input row_t p);
    logic [95:0] w;
    for (int i = 0; i < 16; i++) w[6*i +: 6] = p[i];
    return w;
  endfunction

  // Present a request in IDLE; it must fire in this cycle
  task automatic issue(input logic [7:0] tile, input logic [3:0] row, input logic hf,
                       input logic vf, input logic [11:0] exp_addr);
    io_req_tileIdx = tile;
    io_req_rowIdx  = row;
    io_req_hFlip   = hf;
    io_req_vFlip   = vf;
    io_req_valid   = 1'b1;
    @(negedge clk);
    check("req_ready_idle", 32'(io_req_ready), 32'd1);
    check("rd_en_fire", 32'(io_rdEn), 32'd1);
    check("rd_addr_fire", 32'(io_rdAddr), 32'(exp_addr));
    @(posedge clk); #1;
    io_req_valid = 1'b0;
  endtask

  // Called in the CAPTURE cycle; consumes one full row and checks every beat
  task automatic recv_row(input row_t pat, input bit hf, input bit rnd, input bit chain,
                          input logic [7:0] c_tile, input logic [3:0] c_row);
    row_t e;
    int px = 0;
    int cyc = 0;
    for (int i = 0; i < 16; i++) e[i] = hf ? pat[15-i] : pat[i];
    @(negedge clk);
    check("lat_capture", 32'(io_pop_valid), 32'd0);
    check("rd_en_idle", 32'(io_rdEn), 32'd0);
    check("rd_addr_idle", 32'(io_rdAddr), 32'd0);
    @(posedge clk); #1;
    while (px < 16 && cyc < 200) begin
      io_pop_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (chain && px == 15) begin
        io_req_valid   = 1'b1;
        io_req_tileIdx = c_tile;
        io_req_rowIdx  = c_row;
        io_req_hFlip   = 1'b0;
        io_req_vFlip   = 1'b0;
      end
      @(negedge clk);
      if (cyc == 0) check("lat_first", 32'(io_pop_valid), 32'd1);
      if (io_pop_valid) begin
        check("col_idx", 32'(io_pop_colIdx), 32'(e[px]));
        check("px_idx", 32'(io_pop_pxIdx), 32'(px));
        check("last", 32'(io_pop_last), 32'(px == 15));
        check("transparent", 32'(io_pop_isTransparent), 32'(e[px] == 6'd0));
        check("req_ready_stream", 32'(io_req_ready), 32'(px == 15 && io_pop_ready));
        if (chain && px == 15 && io_pop_ready) begin
          check("rd_en_chain", 32'(io_rdEn), 32'd1);
          check("rd_addr_chain", 32'(io_rdAddr), 32'({c_tile, c_row}));
        end
        if (io_pop_ready) px++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    io_req_valid = 1'b0;
    io_pop_ready = 1'b0;
    check("row_done", 32'(px), 32'd16);
  endtask

  initial begin
    int guard;
    reset = 1'b1;
    io_req_valid = 1'b0;
    io_req_tileIdx = '0;
    io_req_rowIdx = '0;
    io_req_hFlip = 1'b0;
    io_req_vFlip = 1'b0;
    io_pop_ready = 1'b0;
    for (int a = 0; a < 4096; a++) mem[a] = '0;
    for (int i = 0; i < 16; i++) begin
      pat_a[i] = 6'(i + 1);
      pat_b[i] = (i == 4) ? 6'd0 : 6'(i + 1);
      pat_c[i] = 6'(i + 33);
      pat_d[i] = 6'(63 - i);
    end
    mem[12'h035] = pack_row(pat_a);
    mem[12'h036] = pack_row(pat_b);
    mem[12'h03A] = pack_row(pat_c);
    mem[12'hC8F] = pack_row(pat_d);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pop_valid", 32'(io_pop_valid), 32'd0);
    check("rst_rd_en", 32'(io_rdEn), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(io_req_ready), 32'd1);
    check("post_rst_pop_valid", 32'(io_pop_valid), 32'd0);
    @(posedge clk); #1;

    // Plain, hFlip and vFlip fetches
    issue(8'd3, 4'd5, 1'b0, 1'b0, 12'h035);
    recv_row(pat_a, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0);
    @(negedge clk);
    check("ready_after_row", 32'(io_req_ready), 32'd1);
    @(posedge clk); #1;
    issue(8'd3, 4'd5, 1'b1, 1'b0, 12'h035);
    recv_row(pat_a, 1'b1, 1'b0, 1'b0, 8'd0, 4'd0);
    issue(8'd3, 4'd5, 1'b0, 1'b1, 12'h03A);
    recv_row(pat_c, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0);

    // Transparent pixel at index 4, both orientations
    issue(8'd3, 4'd6, 1'b0, 1'b0, 12'h036);
    recv_row(pat_b, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0);
    issue(8'd3, 4'd6, 1'b1, 1'b0, 12'h036);
    recv_row(pat_b, 1'b1, 1'b0, 1'b0, 8'd0, 4'd0);

    // Random consumer stalls
    issue(8'd3, 4'd5, 1'b0, 1'b0, 12'h035);
    recv_row(pat_a, 1'b0, 1'b1, 1'b0, 8'd0, 4'd0);

    // Back-to-back rows with the second request on the last beat
    issue(8'd3, 4'd5, 1'b0, 1'b0, 12'h035);
    recv_row(pat_a, 1'b0, 1'b0, 1'b1, 8'd200, 4'd15);
    recv_row(pat_d, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0);

    // Reset in the middle of a row
    issue(8'd3, 4'd5, 1'b0, 1'b0, 12'h035);
    io_pop_ready = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!(io_pop_valid && io_pop_pxIdx == 4'd7) && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("reach_px7", 32'(io_pop_pxIdx), 32'd7);
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_pop_valid", 32'(io_pop_valid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    io_pop_ready = 1'b0;
    @(negedge clk);
    check("midrst_ready", 32'(io_req_ready), 32'd1);
    check("midrst_pop_idle", 32'(io_pop_valid), 32'd0);
    @(posedge clk); #1;
    issue(8'd200, 4'd15, 1'b0, 1'b0, 12'hC8F);
    recv_row(pat_d, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
